// File: rtl/eth_rx_dst_filter.sv
// Destination-address filter for the MAC RX stream.
// Bytes land in a small rewindable FIFO. A frame becomes read-visible only once
// its destination address has been accepted; rejected and runt frames are
// discarded by moving the write pointer back to the frame start.
module eth_rx_dst_filter #(
    parameter int DEPTH          = 64,
    parameter bit PASS_BROADCAST = 1'b1,
    parameter bit PASS_MULTICAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic [47:0] local_mac,
    input  logic        filter_enable,
    output logic        stat_pass,
    output logic        stat_filtered,
    output logic        stat_runt,
    output logic        stat_truncated
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] start_ptr_q, start_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [47:0]   dst_q, dst_d;
    logic [47:0]   mac_l_q, mac_l_d;
    logic          fe_l_q, fe_l_d;
    logic          pass_q, pass_d;
    logic          filt_q, filt_d;
    logic          runt_q, runt_d;
    logic          trunc_q, trunc_d;

    // Entry layout: {tlast, tuser, data}
    logic [9:0]    mem [DEPTH];
    logic          we;
    logic [9:0]    wdata;

    logic [PW-1:0] fill;
    logic [PW-1:0] wr_inc;
    logic [47:0]   dst_shift;
    logic          full;
    logic          near_full;
    logic          accept;
    logic          rd_en;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign wr_inc    = wr_ptr_q + PW'(1);
    assign full      = (fill == PW'(DEPTH));
    // Writing one more byte would leave only the slot reserved for a
    // truncation marker, so a non-last byte here ends the frame early.
    assign near_full = (fill >= PW'(DEPTH - 2));
    assign dst_shift = {dst_q[39:0], s_axis_tdata};
    assign accept    = !fe_l_q || (dst_shift == mac_l_q) ||
                       (PASS_BROADCAST && (&dst_shift)) ||
                       (PASS_MULTICAST && dst_shift[40]);

    // First-word-fall-through read side: everything below commit_ptr is visible
    assign m_axis_tvalid = (rd_ptr_q != commit_ptr_q);
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = mem[rd_ptr_q[AW-1:0]];
    assign rd_en         = m_axis_tvalid && m_axis_tready;

    assign stat_pass      = pass_q;
    assign stat_filtered  = filt_q;
    assign stat_runt      = runt_q;
    assign stat_truncated = trunc_q;

    // Frame state machine: header collection, address decision, commit/rewind
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + {{(PW-1){1'b0}}, rd_en};
        cnt_d        = cnt_q;
        dst_d        = dst_q;
        mac_l_d      = mac_l_q;
        fe_l_d       = fe_l_q;
        pass_d       = 1'b0;
        filt_d       = 1'b0;
        runt_d       = 1'b0;
        trunc_d      = 1'b0;
        we           = 1'b0;
        wdata        = {s_axis_tlast, s_axis_tuser & s_axis_tlast, s_axis_tdata};

        unique case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    start_ptr_d = wr_ptr_q;
                    mac_l_d     = local_mac;
                    fe_l_d      = filter_enable;
                    dst_d       = {40'd0, s_axis_tdata};
                    cnt_d       = 3'd1;
                    if (full) begin
                        // No room for even the first byte: drop the frame whole
                        filt_d  = 1'b1;
                        state_d = s_axis_tlast ? IDLE : DROP;
                    end else if (s_axis_tlast) begin
                        runt_d  = 1'b1;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_inc;
                        state_d  = HDR;
                    end
                end
            end
            HDR: begin
                if (s_axis_tvalid) begin
                    dst_d = dst_shift;
                    cnt_d = cnt_q + 3'd1;
                    if (full) begin
                        wr_ptr_d = start_ptr_q;
                        filt_d   = 1'b1;
                        state_d  = s_axis_tlast ? IDLE : DROP;
                    end else if (cnt_q == 3'd5) begin
                        if (accept) begin
                            we           = 1'b1;
                            wr_ptr_d     = wr_inc;
                            commit_ptr_d = wr_inc;
                            pass_d       = 1'b1;
                            if (!s_axis_tlast && near_full) begin
                                // Backlog leaves no room for the body: end it here
                                wdata   = {2'b11, s_axis_tdata};
                                trunc_d = 1'b1;
                                state_d = DROP;
                            end else begin
                                state_d = s_axis_tlast ? IDLE : FWD;
                            end
                        end else begin
                            wr_ptr_d = start_ptr_q;
                            filt_d   = 1'b1;
                            state_d  = s_axis_tlast ? IDLE : DROP;
                        end
                    end else if (s_axis_tlast) begin
                        wr_ptr_d = start_ptr_q;
                        runt_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_inc;
                    end
                end
            end
            FWD: begin
                if (s_axis_tvalid) begin
                    we           = 1'b1;
                    wr_ptr_d     = wr_inc;
                    commit_ptr_d = wr_inc;
                    if (!s_axis_tlast && near_full) begin
                        wdata   = {2'b11, s_axis_tdata};
                        trunc_d = 1'b1;
                        state_d = DROP;
                    end else if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            dst_q        <= '0;
            mac_l_q      <= '0;
            fe_l_q       <= 1'b0;
            pass_q       <= 1'b0;
            filt_q       <= 1'b0;
            runt_q       <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            start_ptr_q  <= start_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            dst_q        <= dst_d;
            mac_l_q      <= mac_l_d;
            fe_l_q       <= fe_l_d;
            pass_q       <= pass_d;
            filt_q       <= filt_d;
            runt_q       <= runt_d;
            trunc_q      <= trunc_d;
        end
    end

    // Byte storage; contents are meaningless until covered by commit_ptr
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_eth_rx_dst_filter.sv
// Bench for eth_rx_dst_filter: frame-level reference model with per-cycle
// output comparison, directed scenarios with literal expectations, then
// randomized traffic.
module tb_eth_rx_dst_filter;
    localparam int DEPTH = 16;
    localparam bit PB    = 1'b1;
    localparam bit PM    = 1'b1;
    localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = 8'h0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tuser;
    logic        m_tready = 1'b1;
    logic [47:0] local_mac = MAC_A;
    logic        filter_enable = 1'b1;
    logic        st_pass, st_filt, st_runt, st_trunc;

    eth_rx_dst_filter #(.DEPTH(DEPTH), .PASS_BROADCAST(PB), .PASS_MULTICAST(PM)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .local_mac(local_mac), .filter_enable(filter_enable),
        .stat_pass(st_pass), .stat_filtered(st_filt), .stat_runt(st_runt), .stat_truncated(st_trunc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef logic [9:0] ent_t;  // {last, user, data}
    ent_t        mq[$];         // committed, read-visible bytes
    ent_t        pend[$];       // header bytes awaiting decision
    int          mmode = 0;     // 0 collecting header, 1 forwarding, 2 dropping
    int          mn = 0;
    logic [47:0] mdst = '0, mmac = '0;
    logic        mfe = 1'b0;
    logic        e_pass = 0, e_filt = 0, e_runt = 0, e_trunc = 0;

    always @(posedge clk or negedge rst_n) begin
        int   occ;
        bit   acc;
        ent_t e;
        if (!rst_n) begin
            mq.delete(); pend.delete();
            mmode = 0; mn = 0;
            e_pass = 0; e_filt = 0; e_runt = 0; e_trunc = 0;
        end else begin
            occ = mq.size() + pend.size();
            e_pass = 0; e_filt = 0; e_runt = 0; e_trunc = 0;
            if (m_tready && mq.size() > 0) void'(mq.pop_front());
            if (s_tvalid) begin
                e = {s_tlast, s_tuser & s_tlast, s_tdata};
                if (mmode == 0) begin
                    if (mn == 0) begin mfe = filter_enable; mmac = local_mac; end
                    if (occ == DEPTH) begin
                        pend.delete(); mn = 0; e_filt = 1;
                        mmode = s_tlast ? 0 : 2;
                    end else begin
                        pend.push_back(e);
                        mdst = {mdst[39:0], s_tdata};
                        mn++;
                        if (mn == 6) begin
                            acc = !mfe || (mdst == mmac) || (PB && mdst == BCAST) || (PM && mdst[40]);
                            if (acc) begin
                                e_pass = 1;
                                if (!s_tlast && occ >= DEPTH - 2) begin
                                    pend[5] = {2'b11, s_tdata};
                                    e_trunc = 1; mmode = 2;
                                end else mmode = s_tlast ? 0 : 1;
                                foreach (pend[k]) mq.push_back(pend[k]);
                            end else begin
                                e_filt = 1; mmode = s_tlast ? 0 : 2;
                            end
                            pend.delete(); mn = 0;
                        end else if (s_tlast) begin
                            e_runt = 1; pend.delete(); mn = 0;
                        end
                    end
                end else if (mmode == 1) begin
                    if (!s_tlast && occ >= DEPTH - 2) begin
                        mq.push_back({2'b11, s_tdata}); e_trunc = 1; mmode = 2;
                    end else begin
                        mq.push_back(e);
                        if (s_tlast) mmode = 0;
                    end
                end else if (s_tlast) mmode = 0;
            end
        end
    end

    // ---------------- compare + capture ----------------
    ent_t cap[$];
    int   cnt_pass = 0, cnt_filt = 0, cnt_runt = 0, cnt_trunc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("tvalid", m_tvalid, mq.size() != 0);
            if (mq.size() != 0 && m_tvalid) check("out_entry", {m_tlast, m_tuser, m_tdata}, mq[0]);
            check("stats", {st_pass, st_filt, st_runt, st_trunc}, {e_pass, e_filt, e_runt, e_trunc});
            if (m_tvalid && m_tready) cap.push_back({m_tlast, m_tuser, m_tdata});
            cnt_pass  += int'(st_pass);
            cnt_filt  += int'(st_filt);
            cnt_runt  += int'(st_runt);
            cnt_trunc += int'(st_trunc);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd_rdy = 0;

    task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit u);
        @(posedge clk); #1;
        s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u;
        if (rnd_rdy) m_tready = ($urandom_range(3) != 0);
    endtask

    function automatic logic [7:0] fbyte(input logic [47:0] dst, input int i);
        if (i < 6) return dst[47-8*i -: 8];
        return i[7:0];
    endfunction

    task automatic send_frame(input logic [47:0] dst, input int len, input bit user, input int gap_pct, input bit rnd_pay);
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(0, 8'h0, 0, 0);
            drive(1, (rnd_pay && i >= 6) ? 8'($urandom) : fbyte(dst, i), i == len - 1,
                  (i == len - 1) ? user : (rnd_pay ? 1'($urandom) : 1'b0));
        end
    endtask

    task automatic drain();
        drive(0, 8'h0, 0, 0);
        m_tready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!m_tvalid) break;
        end
        check("drain_done", m_tvalid, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    int b0, bp, bf, br, bt;
    task automatic snap();
        b0 = cap.size(); bp = cnt_pass; bf = cnt_filt; br = cnt_runt; bt = cnt_trunc;
    endtask

    logic [47:0] rdst;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_stats", {st_pass, st_filt, st_runt, st_trunc}, 4'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1: matching 64-byte frame, latency and ordering
        snap();
        for (int i = 0; i < 64; i++) begin
            drive(1, fbyte(MAC_A, i), i == 63, 1'b0);
            if (i == 5) begin
                @(negedge clk);
                check("t1_not_early", m_tvalid, 1'b0);
            end
            if (i == 6) begin
                @(negedge clk);
                check("t1_first_lat", {m_tvalid, m_tdata}, {1'b1, 8'h02});
            end
        end
        drain();
        check("t1_len", cap.size() - b0, 64);
        for (int i = 0; i < 64 && b0 + i < cap.size(); i++)
            check("t1_byte", cap[b0+i], {i == 63, 1'b0, fbyte(MAC_A, i)});
        check("t1_pass", cnt_pass - bp, 1);

        // T2: non-matching then matching, back to back
        snap();
        send_frame(MAC_B, 60, 0, 0, 0);
        send_frame(MAC_A, 20, 1, 0, 0);
        drain();
        check("t2_filt", cnt_filt - bf, 1);
        check("t2_pass", cnt_pass - bp, 1);
        check("t2_len", cap.size() - b0, 20);
        if (cap.size() - b0 == 20) begin
            check("t2_first", cap[b0], {2'b00, 8'h02});
            check("t2_last", cap[b0+19], {2'b11, 8'h13});
        end

        // T3: broadcast and multicast both pass
        snap();
        send_frame(BCAST, 10, 0, 0, 0);
        send_frame(MCAST, 10, 0, 0, 0);
        drain();
        check("t3_pass", cnt_pass - bp, 2);
        check("t3_len", cap.size() - b0, 20);

        // T4: runt
        snap();
        send_frame(MAC_A, 4, 0, 0, 0);
        drain();
        check("t4_runt", cnt_runt - br, 1);
        check("t4_len", cap.size() - b0, 0);

        // T5: stalled output, frame truncated at 15 bytes
        snap();
        m_tready = 1'b0;
        send_frame(MAC_A, 40, 0, 0, 0);
        drive(0, 8'h0, 0, 0);
        repeat (3) @(negedge clk);
        check("t5_held", cap.size() - b0, 0);
        drain();
        check("t5_len", cap.size() - b0, 15);
        if (cap.size() - b0 == 15) check("t5_trunc_byte", cap[b0+14], {2'b11, 8'h0E});
        check("t5_trunc", cnt_trunc - bt, 1);
        check("t5_pass", cnt_pass - bp, 1);

        // T6: reset in the middle of a forwarded frame
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) drive(1, fbyte(MAC_A, i), 0, 0);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("t6_rst_tvalid", m_tvalid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_tready = 1'b1;
        snap();
        send_frame(MAC_A, 30, 0, 0, 0);
        drain();
        check("t6_len", cap.size() - b0, 30);
        check("t6_pass", cnt_pass - bp, 1);

        // Random traffic
        rnd_rdy = 1;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(9) == 0) local_mac = {7'($urandom), 1'b0, 40'($urandom)};
            filter_enable = ($urandom_range(4) != 0);
            case ($urandom_range(4))
                0: rdst = local_mac;
                1: rdst = local_mac ^ 48'h1;
                2: rdst = BCAST;
                3: rdst = MCAST;
                default: rdst = {16'($urandom), 32'($urandom)};
            endcase
            send_frame(rdst, $urandom_range(1, 30), 1'($urandom), ($urandom_range(1) != 0) ? 20 : 0, 1);
            if ($urandom_range(3) == 0) filter_enable = ~filter_enable;
            repeat ($urandom_range(2)) drive(0, 8'h0, 0, 0);
        end
        rnd_rdy = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
